fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage feeding the control unit's 32-bit `instr` input. It holds the program counter, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned words in a small FIFO. Buffered instructions are presented to decode with a valid/ready handshake. A redirect input from branch/jump resolution flushes all buffered and in-flight instructions and restarts fetch at a new PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte address of the first fetch after reset.
- `BUF_DEPTH`, default 2: instruction FIFO entries; power of 2, ≥2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `imem_req`  out  1  read request valid.
- `imem_addr`  out  32  word-aligned byte address of the request.
- `imem_gnt`  in  1  memory accepts the request this cycle (`imem_req && imem_gnt` = issued).
- `imem_rvalid`  in  1  read data valid; in-order; at least one cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  FIFO head valid.
- `instr`  out  32  FIFO head instruction word.
- `instr_pc`  out  32  byte address of `instr`.
- `instr_ready`  in  1  decode consumes the head when `instr_valid && instr_ready`.
- `redirect`  in  1  flush and restart fetch.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored and treated as 00.

## Operation
- Registers: `fetch_pc` (32), FIFO storage of {pc, word} × BUF_DEPTH, `count` (0..BUF_DEPTH), `out_pc` (pc of the in-flight request), and a 3-state FSM.
- FSM states:
  - S_REQ: request phase.
  - S_WAIT: one request outstanding; response will be kept.
  - S_DROP: one request outstanding; response will be discarded.
- At most one request is outstanding at any time.
- `imem_req` = (state == S_REQ) && (count_after_pop < BUF_DEPTH).
  - count_after_pop = count − (instr_valid && instr_ready).
- `imem_addr` = `fetch_pc`.
- S_REQ, on grant: `out_pc` ← `fetch_pc`; `fetch_pc` ← `fetch_pc` + 4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0); go to S_WAIT.
- S_WAIT, on `imem_rvalid`: push {`out_pc`, `imem_rdata`}; go to S_REQ.
- S_DROP, on `imem_rvalid`: discard the data; go to S_REQ.
- `imem_rvalid` in S_REQ is a protocol error; ignore it.
- FIFO rules:
  - `instr_valid` = (count != 0).
  - `instr`/`instr_pc` are the head entry, driven from registers.
  - Push and pop in the same cycle are permitted; count is unchanged.
  - Push when full cannot occur: request gating guarantees space.
- Redirect has highest priority; in the cycle `redirect` is high:
  - count ← 0 and FIFO pointers reset. Any pop that cycle is still treated as taken and has no further effect.
  - `fetch_pc` ← {`redirect_pc`[31:2], 2'b00}.
  - Next state:
    - S_REQ with no grant: S_REQ.
    - S_REQ with grant, or S_WAIT without rvalid: S_DROP.
    - S_WAIT or S_DROP with rvalid: data discarded; S_REQ.
    - S_DROP without rvalid: S_DROP.
  - A request granted in the redirect cycle uses the old `fetch_pc`, and its response is dropped.
- Reset:
  - state = S_REQ, `fetch_pc` = RESET_PC, count = 0, `out_pc` = 0, FIFO pointers = 0.
  - Outputs during reset: `imem_req`=0, `instr_valid`=0, `imem_addr`=RESET_PC. `instr` and `instr_pc` = 0 (storage is cleared).
  - A response arriving after reset for a pre-reset request is ignored (state S_REQ).

## Timing
- First `imem_req` is in the first cycle after `rst` deasserts.
- Best-case fetch latency: grant in cycle N, rvalid in N+1, `instr_valid` in N+2. There is no bypass from `imem_rdata` to `instr`.
- Peak throughput is one instruction per 2 cycles: the next request issues in the cycle after a response.
- Redirect in cycle R with no outstanding request: `imem_req` with the new address in R+1.
- `imem_req`/`imem_addr` stay stable until granted, except across a redirect, where the request may be abandoned and the address changes.
- Backpressure: with `instr_ready`=0, fetch stops once count + outstanding = BUF_DEPTH.

## Test plan
- Reset release, RESET_PC=0, memory grants immediately with 1-cycle response (`rdata` = addr ^ 32'hA5A5_0000), `instr_ready`=1.
  -> `instr_pc` sequence 0, 4, 8, 12, one instruction every 2 cycles; `instr` matches each pc.
- `instr_ready`=0 for 10 cycles, then 1.
  -> exactly 2 entries fetched (pcs 0 and 4), `imem_req` low while full; on release, pcs 0, 4, 8 are delivered in order with none lost.
- Redirect to 32'h0000_0100 while a request for pc 8 is outstanding.
  -> the pc 8 response is dropped and the FIFO is emptied; the next request is at 32'h100; the next `instr_pc` is 32'h100.
- Redirect in the same cycle as `imem_rvalid`, and redirect in the same cycle as grant (`redirect_pc` = 32'h203).
  -> neither word is delivered; the next delivered `instr_pc` is 32'h200.
- `fetch_pc` at 32'hFFFF_FFFC with grant.
  -> next `imem_addr` is 32'h0000_0000.
- `rst` asserted mid-wait (outstanding request), response arrives during reset.
  -> all outputs take reset values immediately (asynchronous); the response is ignored; the first post-reset request is at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Instruction-memory request/response channel and decode-side
//                valid/ready channel of the fetch stage, plus the redirect.
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_unit_if;
  // Instruction memory side
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  // Decode side
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  // Branch/jump resolution
  logic        redirect;
  logic [31:0] redirect_pc;

  // Fetch unit view
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );

  // Memory / decode / branch environment view
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Holds the PC, issues one word read
//                at a time to instruction memory, buffers returned words in a
//                small FIFO and presents them to decode. A redirect flushes
//                the FIFO, drops any in-flight response and restarts fetch.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  wire logic      clk,
  input  wire logic      rst,
  fetch_unit_if.master   bus
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // free to request
    S_WAIT = 2'd1,  // one request outstanding, response kept
    S_DROP = 2'd2   // one request outstanding, response discarded
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_out_pc;
  logic [31:0]      r_pc_mem   [BUF_DEPTH];
  logic [31:0]      r_word_mem [BUF_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_valid;
  logic             w_pop;
  logic [CNT_W-1:0] w_cnt_after_pop;
  logic             w_req;
  logic             w_issue;
  logic             w_push;
  logic [31:0]      w_redirect_pc;

  assign w_valid         = (r_count != '0);
  assign w_pop           = w_valid && bus.instr_ready;
  assign w_cnt_after_pop = r_count - CNT_W'(w_pop);
  // Low two address bits are forced to zero so fetch stays word aligned
  assign w_redirect_pc   = bus.redirect_pc & 32'hFFFF_FFFC;

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.instr_valid = w_valid;
  assign bus.instr       = r_word_mem[r_rd_ptr];
  assign bus.instr_pc    = r_pc_mem[r_rd_ptr];

  // Next-state and handshake decode; redirect overrides the normal flow
  always_comb begin
    w_state_nxt = r_state;
    // Request is held off during reset and whenever the slot it would fill
    // is not guaranteed free after this cycle's pop
    w_req   = !rst && (r_state == S_REQ) && (w_cnt_after_pop < c_DEPTH);
    w_issue = w_req && bus.imem_gnt;
    w_push  = (r_state == S_WAIT) && bus.imem_rvalid && !bus.redirect;
    if (bus.redirect) begin
      case (r_state)
        S_REQ:   w_state_nxt = w_issue ? S_DROP : S_REQ;
        S_WAIT,
        S_DROP:  w_state_nxt = bus.imem_rvalid ? S_REQ : S_DROP;
        default: w_state_nxt = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ:   if (w_issue)         w_state_nxt = S_WAIT;
        S_WAIT:  if (bus.imem_rvalid) w_state_nxt = S_REQ;
        S_DROP:  if (bus.imem_rvalid) w_state_nxt = S_REQ;
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_REQ;
    else     r_state <= w_state_nxt;
  end

  // Fetch PC and in-flight PC; a grant in a redirect cycle still records
  // the old PC but its response is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_out_pc   <= '0;
    end else begin
      if (w_issue) r_out_pc <= r_fetch_pc;
      if (bus.redirect)  r_fetch_pc <= w_redirect_pc;
      else if (w_issue)  r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  // FIFO pointers and occupancy; redirect empties the buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // FIFO storage; cleared on reset so the head reads zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_word_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_out_pc;
      r_word_mem[r_wr_ptr] <= bus.imem_rdata;
    end
  end

endmodule
`default_nettype wire
